timer_counter: RTL and testbench

TIMER_COUNTER -- requirements
Module: timer_counter

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_counter.sv | 108 ++++++++++
 tb/tb_timer_counter.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared constants for the timer/counter peripheral:
// FSM state codes, register word offsets and mode codes.
package timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped down-counter with one-shot / auto-reload modes
// and a level interrupt gated by the IM bit.
module timer_counter
   import timer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   logic [1:0]  state_q, state_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic [31:0] preset_q, preset_d;
   logic [31:0] count_q, count_d;
   logic        int_flag_q, int_flag_d;

   logic        en;
   logic [1:0]  mode;
   logic        im;
   logic        wr_ctrl;
   logic        wr_preset;
   logic        int_set;

   assign en        = ctrl_q[0];
   assign mode      = ctrl_q[2:1];
   assign im        = ctrl_q[3];
   assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
   assign wr_preset = WE && (Addr == ADDR_PRESET);

   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      preset_d   = preset_q;
      count_d    = count_q;
      int_flag_d = int_flag_q;
      int_set    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d = preset_q;
            state_d = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_d = ST_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               int_set = 1'b1;
               state_d = ST_INT;
            end
         end
         ST_INT: begin
            if (mode == MODE_RELOAD) begin
               int_flag_d = 1'b0;
               state_d    = ST_LOAD;
            end else begin
               ctrl_d[0] = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Bus writes override the FSM's own Enable clear; a flag set still wins.
      if (wr_ctrl)   ctrl_d   = Din[3:0];
      if (wr_preset) preset_d = Din;
      if (wr_ctrl || wr_preset) int_flag_d = 1'b0;
      if (int_set) int_flag_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 4'd0;
         preset_q   <= 32'd0;
         count_q    <= 32'd0;
         int_flag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         preset_q   <= preset_d;
         count_q    <= count_d;
         int_flag_q <= int_flag_d;
      end
   end

   always_comb begin
      Dout = 32'd0;
      unique case (Addr)
         ADDR_CTRL:   Dout = {28'd0, ctrl_q};
         ADDR_PRESET: Dout = preset_q;
         ADDR_COUNT:  Dout = count_q;
         default:     Dout = 32'd0;
      endcase
   end

   assign IRQ = im & int_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench: stimulus pushes model expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_timer_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   timer_counter dut (
      .clk   (clk),
      .reset (reset),
      .Addr  (Addr),
      .WE    (WE),
      .Din   (Din),
      .Dout  (Dout),
      .IRQ   (IRQ)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] dout;
      logic        irq;
      logic        flag;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: phase 0 idle, 1 load, 2 counting, 3 expired
   int          m_phase;
   logic        m_en;
   logic [1:0]  m_mode;
   logic        m_im;
   logic [31:0] m_preset;
   logic [31:0] m_count;
   logic        m_flag;

   function automatic logic [31:0] m_read(input logic [1:0] a);
      if (a == 2'd0) return {28'd0, m_im, m_mode, m_en};
      if (a == 2'd1) return m_preset;
      if (a == 2'd2) return m_count;
      return 32'd0;
   endfunction

   task automatic m_step(input logic rst, input logic [1:0] a,
                         input logic we, input logic [31:0] d);
      int          ph;
      logic        en, im, fl, set;
      logic [1:0]  md;
      logic [31:0] pr, ct;
      if (rst) begin
         m_phase = 0; m_en = 0; m_mode = 0; m_im = 0;
         m_preset = 0; m_count = 0; m_flag = 0;
         return;
      end
      ph = m_phase; en = m_en; md = m_mode; im = m_im;
      pr = m_preset; ct = m_count; fl = m_flag; set = 0;
      if (m_phase == 0) begin
         if (m_en) ph = 1;
      end else if (m_phase == 1) begin
         ct = m_preset; ph = 2;
      end else if (m_phase == 2) begin
         if (!m_en) ph = 0;
         else if (m_count >= 2) ct = m_count - 1;
         else begin ct = 0; set = 1; ph = 3; end
      end else begin
         if (m_mode == 2'b01) begin fl = 0; ph = 1; end
         else begin en = 0; ph = 0; end
      end
      if (we && a == 2'd0) begin
         en = d[0]; md = d[2:1]; im = d[3];
      end
      if (we && a == 2'd1) pr = d;
      if (we && (a == 2'd0 || a == 2'd1)) fl = 0;
      if (set) fl = 1;
      m_phase = ph; m_en = en; m_mode = md; m_im = im;
      m_preset = pr; m_count = ct; m_flag = fl;
   endtask

   task automatic cycle(input logic rst, input logic [1:0] a,
                        input logic we, input logic [31:0] d,
                        input bit chk);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; Addr = a; WE = we; Din = d;
      if (chk) begin
         e.addr = a;
         e.dout = m_read(a);
         e.irq  = m_im & m_flag;
         e.flag = m_flag;
         sb.push_back(e);
      end
      m_step(rst, a, we, d);
   endtask

   task automatic rd(input logic [1:0] a, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, a, 1'b0, 32'd0, 1'b1);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cycle(1'b0, a, 1'b1, d, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (Dout !== e.dout) begin
               errors++;
               $display("FAIL dout addr=%0d got=%h exp=%h t=%0t",
                        e.addr, Dout, e.dout, $time);
            end
            checks++;
            if (IRQ !== e.irq) begin
               errors++;
               $display("FAIL irq got=%b exp=%b t=%0t", IRQ, e.irq, $time);
            end
            checks++;
            if (dut.int_flag_q !== e.flag) begin
               errors++;
               $display("FAIL int_flag got=%b exp=%b t=%0t",
                        dut.int_flag_q, e.flag, $time);
            end
         end
      end
   end

   initial begin : stim
      logic [1:0]  a;
      logic        we;
      logic [31:0] d;
      int          wait_n;
      reset = 1'b1; Addr = 2'd0; WE = 1'b0; Din = 32'd0;
      cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b0);
      cycle(1'b1, 2'd0, 1'b0, 32'd0, 1'b1);
      rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1); rd(2'd3, 1);

      // one-shot with IM
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h9);
      rd(2'd2, 8);
      rd(2'd0, 2);
      // reset while IRQ is high
      cycle(1'b1, 2'd2, 1'b0, 32'd0, 1'b1);
      rd(2'd0, 1); rd(2'd1, 1); rd(2'd2, 1);

      // one-shot, IM off
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h1);
      rd(2'd2, 8);
      rd(2'd0, 1);

      // auto-reload
      wr(2'd1, 32'd2);
      wr(2'd0, 32'hB);
      rd(2'd2, 14);

      // stop mid-count and restart
      wr(2'd1, 32'd10);
      wr(2'd0, 32'h9);
      rd(2'd2, 6);
      wr(2'd0, 32'h8);
      rd(2'd2, 5);
      wr(2'd0, 32'h9);
      rd(2'd2, 5);

      // ignored writes, unmapped read, masked CTRL
      cycle(1'b0, 2'd2, 1'b1, 32'h1234, 1'b1);
      rd(2'd2, 2);
      cycle(1'b0, 2'd3, 1'b1, 32'hDEAD, 1'b1);
      rd(2'd3, 1);
      wr(2'd0, 32'hFFFF_FFF9);
      rd(2'd0, 1);
      rd(2'd2, 3);
      // reset mid-count
      cycle(1'b1, 2'd2, 1'b1, 32'h5, 1'b1);
      rd(2'd0, 1); rd(2'd2, 2);

      // P=0 behaves as P=1
      wr(2'd1, 32'd0);
      wr(2'd0, 32'hB);
      rd(2'd2, 8);

      for (int i = 0; i < 4000; i++) begin
         a  = 2'($urandom_range(0, 3));
         we = ($urandom_range(0, 15) == 0);
         d  = $urandom;
         if (a == 2'd1 && $urandom_range(0, 7) != 0)
            d = 32'($urandom_range(0, 6));
         if (a == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
         cycle(($urandom_range(0, 299) == 0), a, we, d, 1'b1);
      end

      wait_n = 0;
      while (sb.size() > 0 && wait_n < 10) begin
         @(posedge clk);
         wait_n++;
      end
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain left=%0d exp=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
